// File: rtl/meduram_rd_agent_if.sv
// Request/response channel plus the core read-port wires of one meduram read agent.
// The master modport is the agent; the slave modport is the requester/core side.
interface meduram_rd_agent_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_wrcol;
    logic                  rsp_err;
    logic                  rden;
    logic [ADDR_WIDTH-1:0] rdaddr;
    logic [DATA_WIDTH-1:0] rddata;
    logic [1:0]            rdcollision;

    modport master (
        input  req_valid, req_addr, rsp_ready, rddata, rdcollision,
        output req_ready, rsp_valid, rsp_data, rsp_wrcol, rsp_err, rden, rdaddr
    );

    modport slave (
        output req_valid, req_addr, rsp_ready, rddata, rdcollision,
        input  req_ready, rsp_valid, rsp_data, rsp_wrcol, rsp_err, rden, rdaddr
    );
endinterface

// File: rtl/meduram_rd_agent.sv
// Read client for one meduram core read port: issues a single read per request,
// samples at the fixed core latency and retries reads that lost a read collision.
module meduram_rd_agent #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int AGENT_ID   = 1,
    parameter int MAX_RETRY  = 3
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    meduram_rd_agent_if.master   bus
);

    localparam int               LAT_W        = $clog2(RD_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD     = LAT_W'(RD_LATENCY);
    localparam logic [LAT_W-1:0] LAT_ONE      = LAT_W'(1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);
    localparam logic             LOSES_RD_COL = (AGENT_ID == 2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    state_t                state_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_wrcol_q;
    logic                  rsp_err_q;
    logic                  rden_q;
    logic [ADDR_WIDTH-1:0] rdaddr_q;
    logic [3:0]            retry_q;
    logic [3:0]            backoff_q;
    logic [LAT_W-1:0]      lat_q;

    logic                  lost_s;
    logic [3:0]            retry_d;

    // Only the second core read port can lose a read collision.
    assign lost_s  = LOSES_RD_COL && bus.rdcollision[1];
    assign retry_d = retry_q + 4'd1;

    // Request FSM with all outputs held in registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= {DATA_WIDTH{1'b0}};
            rsp_wrcol_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rden_q      <= 1'b0;
            rdaddr_q    <= {ADDR_WIDTH{1'b0}};
            retry_q     <= 4'd0;
            backoff_q   <= 4'd0;
            lat_q       <= {LAT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        rdaddr_q    <= bus.req_addr;
                        retry_q     <= 4'd0;
                        req_ready_q <= 1'b0;
                        rden_q      <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    rden_q  <= 1'b0;
                    lat_q   <= LAT_LOAD;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    lat_q <= lat_q - LAT_ONE;
                    if (lat_q == LAT_ONE) begin
                        // A lost read with retries left backs off for (retries) cycles.
                        if (lost_s && (retry_q < RETRY_MAX)) begin
                            retry_q   <= retry_d;
                            backoff_q <= retry_d;
                            state_q   <= ST_BACKOFF;
                        end else begin
                            rsp_data_q  <= bus.rddata;
                            rsp_wrcol_q <= bus.rdcollision[0];
                            rsp_err_q   <= lost_s;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (backoff_q <= 4'd1) begin
                        rden_q  <= 1'b1;
                        state_q <= ST_ISSUE;
                    end else begin
                        backoff_q <= backoff_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rden_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_wrcol = rsp_wrcol_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rden      = rden_q;
    assign bus.rdaddr    = rdaddr_q;

endmodule

// File: tb/tb_meduram_rd_agent.sv
// Directed bench for meduram_rd_agent: a port-1 agent and a port-2 agent (MAX_RETRY=2)
// in front of a small latency-1 core model with a bench-driven competing reader.
`timescale 1ns/1ps
module tb_meduram_rd_agent;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    meduram_rd_agent_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) b1 ();
    meduram_rd_agent_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) b2 ();

    meduram_rd_agent #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RD_LATENCY(1), .AGENT_ID(1), .MAX_RETRY(3))
        u_a1 (.aclk(aclk), .aresetn(aresetn), .bus(b1));
    meduram_rd_agent #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RD_LATENCY(1), .AGENT_ID(2), .MAX_RETRY(2))
        u_a2 (.aclk(aclk), .aresetn(aresetn), .bus(b2));

    logic [7:0] mem [8];
    logic       wcol [8];
    logic       force_rc1;
    logic       p1_rden;
    logic [2:0] p1_addr;
    int         n_rd1 = 0;
    int         n_rd2 = 0;
    int         n_pass = 0;
    int         n_total = 0;

    // Core model: one-cycle read latency; garbage outside valid read cycles.
    always @(posedge aclk) begin
        if (b1.rden) begin
            b1.rddata      <= mem[b1.rdaddr];
            b1.rdcollision <= {force_rc1, wcol[b1.rdaddr]};
        end else begin
            b1.rddata      <= 8'hEE;
            b1.rdcollision <= 2'b11;
        end
        if (b2.rden) begin
            b2.rddata      <= mem[b2.rdaddr];
            b2.rdcollision <= {(p1_rden && (p1_addr[2:1] == b2.rdaddr[2:1])), wcol[b2.rdaddr]};
        end else begin
            b2.rddata      <= 8'hEE;
            b2.rdcollision <= 2'b11;
        end
        if (b1.rden) n_rd1 <= n_rd1 + 1;
        if (b2.rden) n_rd2 <= n_rd2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int base1;
        int base2;
        int lat;

        for (int i = 0; i < 8; i++) begin
            mem[i]  = 8'h00;
            wcol[i] = 1'b0;
        end
        force_rc1    = 1'b0;
        p1_rden      = 1'b0;
        p1_addr      = 3'd0;
        aresetn      = 1'b0;
        b1.req_valid = 1'b1;
        b1.req_addr  = 3'd0;
        b1.rsp_ready = 1'b0;
        b2.req_valid = 1'b1;
        b2.req_addr  = 3'd0;
        b2.rsp_ready = 1'b0;

        // Reset held with a pending request
        step();
        step();
        chk("rst_req_ready", 32'(b1.req_ready), 32'd1);
        chk("rst_rden", 32'(b1.rden), 32'd0);
        chk("rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(b1.rsp_data), 32'h00);
        chk("rst_rden2", 32'(b2.rden), 32'd0);
        b1.req_valid = 1'b0;
        b2.req_valid = 1'b0;
        aresetn      = 1'b1;
        base1 = n_rd1;
        base2 = n_rd2;
        step(); step(); step();
        chk("idle_no_rden", 32'((n_rd1 - base1) + (n_rd2 - base2)), 32'd0);

        // Single read on port-1 agent
        mem[2] = 8'hA5;
        base1 = n_rd1;
        b1.req_addr  = 3'd2;
        b1.req_valid = 1'b1;
        step();
        b1.req_valid = 1'b0;
        chk("t1_rden", 32'(b1.rden), 32'd1);
        chk("t1_rdaddr", 32'(b1.rdaddr), 32'd2);
        chk("t1_req_ready_busy", 32'(b1.req_ready), 32'd0);
        step();
        chk("t1_rden_drop", 32'(b1.rden), 32'd0);
        chk("t1_not_yet_valid", 32'(b1.rsp_valid), 32'd0);
        step();
        chk("t1_rsp_valid", 32'(b1.rsp_valid), 32'd1);
        chk("t1_rsp_data", 32'(b1.rsp_data), 32'hA5);
        chk("t1_rsp_wrcol", 32'(b1.rsp_wrcol), 32'd0);
        chk("t1_rsp_err", 32'(b1.rsp_err), 32'd0);
        b1.rsp_ready = 1'b1;
        step();
        b1.rsp_ready = 1'b0;
        chk("t1_rsp_drop", 32'(b1.rsp_valid), 32'd0);
        chk("t1_req_ready_back", 32'(b1.req_ready), 32'd1);
        chk("t1_data_kept", 32'(b1.rsp_data), 32'hA5);
        chk("t1_one_rden", 32'(n_rd1 - base1), 32'd1);

        // Write collision at addr 5 (port 1 wins with 0x11); read-collision flag ignored on port 1
        mem[5]    = 8'h11;
        wcol[5]   = 1'b1;
        force_rc1 = 1'b1;
        base1 = n_rd1;
        b1.req_addr  = 3'd5;
        b1.req_valid = 1'b1;
        step();
        b1.req_valid = 1'b0;
        step();
        step();
        chk("t2_rsp_valid", 32'(b1.rsp_valid), 32'd1);
        chk("t2_rsp_data", 32'(b1.rsp_data), 32'h11);
        chk("t2_rsp_wrcol", 32'(b1.rsp_wrcol), 32'd1);
        chk("t2_rsp_err", 32'(b1.rsp_err), 32'd0);
        chk("t2_one_rden", 32'(n_rd1 - base1), 32'd1);
        b1.rsp_ready = 1'b1;
        step();
        b1.rsp_ready = 1'b0;
        force_rc1 = 1'b0;

        // Port-2 agent loses one read collision, then retries after a one-cycle backoff
        mem[5]  = 8'h3C;
        wcol[5] = 1'b0;
        base2 = n_rd2;
        b2.req_addr  = 3'd5;
        b2.req_valid = 1'b1;
        step();
        b2.req_valid = 1'b0;
        p1_rden = 1'b1;
        p1_addr = 3'd4;
        chk("t3_rden1", 32'(b2.rden), 32'd1);
        step();
        p1_rden = 1'b0;
        step();
        chk("t3_backoff_no_rden", 32'(b2.rden), 32'd0);
        chk("t3_backoff_no_rsp", 32'(b2.rsp_valid), 32'd0);
        step();
        chk("t3_rden2", 32'(b2.rden), 32'd1);
        chk("t3_rdaddr2", 32'(b2.rdaddr), 32'd5);
        step();
        chk("t3_wait_no_rsp", 32'(b2.rsp_valid), 32'd0);
        step();
        chk("t3_rsp_valid", 32'(b2.rsp_valid), 32'd1);
        chk("t3_rsp_data", 32'(b2.rsp_data), 32'h3C);
        chk("t3_rsp_err", 32'(b2.rsp_err), 32'd0);
        chk("t3_two_rden", 32'(n_rd2 - base2), 32'd2);
        b2.rsp_ready = 1'b1;
        step();
        b2.rsp_ready = 1'b0;

        // Retry exhaustion: competing reader collides on every attempt
        base2 = n_rd2;
        p1_rden = 1'b1;
        p1_addr = 3'd4;
        b2.req_addr  = 3'd5;
        b2.req_valid = 1'b1;
        step();
        b2.req_valid = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while ((b2.rsp_valid !== 1'b1) && (lat < 30));
        chk("t4_latency", 32'(lat), 32'd9);
        chk("t4_rsp_err", 32'(b2.rsp_err), 32'd1);
        chk("t4_rsp_data", 32'(b2.rsp_data), 32'h3C);
        chk("t4_three_rden", 32'(n_rd2 - base2), 32'd3);
        p1_rden = 1'b0;
        b2.rsp_ready = 1'b1;
        step();
        b2.rsp_ready = 1'b0;

        // Backpressure on port-1 agent, then reset while in RESP
        mem[3]  = 8'h5A;
        wcol[3] = 1'b1;
        b1.req_addr  = 3'd3;
        b1.req_valid = 1'b1;
        step();
        b1.req_valid = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", 32'(b1.rsp_valid), 32'd1);
            chk("t5_hold_data", 32'(b1.rsp_data), 32'h5A);
            chk("t5_hold_wrcol", 32'(b1.rsp_wrcol), 32'd1);
            chk("t5_hold_req_ready", 32'(b1.req_ready), 32'd0);
            step();
        end
        aresetn = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("t5_rst_rsp_data", 32'(b1.rsp_data), 32'h00);
        chk("t5_rst_req_ready", 32'(b1.req_ready), 32'd1);
        aresetn = 1'b1;
        step();
        base1 = n_rd1;
        b1.req_addr  = 3'd2;
        b1.req_valid = 1'b1;
        step();
        b1.req_valid = 1'b0;
        step();
        step();
        chk("t5_after_rst_valid", 32'(b1.rsp_valid), 32'd1);
        chk("t5_after_rst_data", 32'(b1.rsp_data), 32'hA5);
        chk("t5_after_rst_err", 32'(b1.rsp_err), 32'd0);
        chk("t5_after_rst_rden", 32'(n_rd1 - base1), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
